// File: rtl/tdm_demux.sv
// TDM receive-side demultiplexer: serial slot words into a shadow buffer, whole-frame commit to o_y.
// Optional parity checking is built when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_gbar,
    input  logic            i_fsync,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic [W:0]      i_din,
    output logic            o_perr,
`else
    input  logic [W-1:0]    i_din,
`endif
    output logic [N*W-1:0]  o_y,
    output logic            o_frame_vld,
    output logic            o_sync_err,
    output logic            o_lock,
    output logic [CW-1:0]   o_ch
);

    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [CW-1:0] AFTER_0 = (N == 1) ? '0 : CW'(1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CW-1:0]      r_ch;
    logic [CW-1:0]      w_next_ch;
    logic [CW-1:0]      w_idx;
    logic               w_store;
    logic               w_start;
    logic               w_commit;
    logic               w_commit_ok;
    logic               w_sync_err;
    logic [W-1:0]       w_data;
    logic [W-1:0]       r_shadow [N];
    logic [N*W-1:0]     w_frame;
    logic [N*W-1:0]     r_y;
    logic               r_frame_vld;
    logic               r_sync_err;

`ifdef TDM_DEMUX_PARITY_EN
    logic w_perr_word;
    logic w_bad_frame;
    logic r_bad;
    logic r_perr;

    assign w_data      = i_din[W-1:0];
    assign w_perr_word = ^i_din;
    // A new slot 0 starts a fresh frame, so the old bad mark is dropped there.
    assign w_bad_frame = (w_start ? 1'b0 : r_bad) | w_perr_word;
    assign w_commit_ok = w_commit & ~w_bad_frame;
    assign o_perr      = r_perr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bad  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_store & w_perr_word;
            if (w_store) r_bad <= w_bad_frame;
        end
    end
`else
    assign w_data      = i_din;
    assign w_commit_ok = w_commit;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_ch    = r_ch;
        w_store      = 1'b0;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        w_sync_err   = 1'b0;
        if (!i_gbar) begin
            case (r_state)
                HUNT: begin
                    if (i_fsync) begin
                        w_store      = 1'b1;
                        w_start      = 1'b1;
                        w_commit     = (N == 1);
                        w_next_ch    = AFTER_0;
                        w_next_state = RECV;
                    end
                end
                RECV: begin
                    if (r_ch == '0) begin
                        if (i_fsync) begin
                            w_store   = 1'b1;
                            w_start   = 1'b1;
                            w_commit  = (N == 1);
                            w_next_ch = AFTER_0;
                        end else begin
                            w_sync_err   = 1'b1;
                            w_next_ch    = '0;
                            w_next_state = HUNT;
                        end
                    end else if (i_fsync) begin
                        // Misplaced marker: abandon the partial frame and restart on this word.
                        w_sync_err = 1'b1;
                        w_store    = 1'b1;
                        w_start    = 1'b1;
                        w_next_ch  = AFTER_0;
                    end else begin
                        w_store = 1'b1;
                        if (r_ch == LAST) begin
                            w_commit  = 1'b1;
                            w_next_ch = '0;
                        end else begin
                            w_next_ch = r_ch + CW'(1);
                        end
                    end
                end
                default: begin
                    w_next_state = HUNT;
                    w_next_ch    = '0;
                end
            endcase
        end
    end

    assign w_idx = w_start ? '0 : r_ch;

    // The last slot goes straight from the input into o_y, never through the buffer.
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < N; k++) begin
            w_frame[k*W +: W] = (k == N - 1) ? w_data : r_shadow[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= HUNT;
            r_ch        <= '0;
            r_y         <= '0;
            r_frame_vld <= 1'b0;
            r_sync_err  <= 1'b0;
            for (int k = 0; k < N; k++) r_shadow[k] <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ch        <= w_next_ch;
            r_frame_vld <= w_commit_ok;
            r_sync_err  <= w_sync_err;
            if (w_commit_ok) r_y <= w_frame;
            for (int k = 0; k < N; k++) begin
                if (w_store && (w_idx == CW'(k))) r_shadow[k] <= w_data;
            end
        end
    end

    assign o_y         = r_y;
    assign o_frame_vld = r_frame_vld;
    assign o_sync_err  = r_sync_err;
    assign o_lock      = (r_state == RECV);
    assign o_ch        = r_ch;

endmodule
